// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset-release sequencer.
package rst_seq_pkg;

    // RELEASE has no encoding of its own: it is the registered WAIT->RUN step.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } rst_seq_state_t;

    // Counter width large enough to hold the longest terminal count plus one.
    function automatic int unsigned rst_seq_cnt_w(input int unsigned min_hold,
                                                  input int unsigned timeout);
        int unsigned m;
        m = (min_hold > timeout) ? min_hold : timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Up-counter with synchronous clear and enable; flags when it sits at its terminal count.
module rst_seq_cnt #(
    parameter int W  = 7,
    parameter int TC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign at_tc = (cnt_q == W'(TC));

endmodule

// File: rtl/rst_release_seq.sv
// Reset-release sequencer: holds rst_out high for MIN_HOLD cycles, then waits for
// ready_in to be stable for STABLE cycles before releasing, or flags a timeout.
// Optional macro RST_SEQ_SVA_EN compiles in embedded concurrent assertions.
module rst_release_seq
    import rst_seq_pkg::*;
#(
    parameter int MIN_HOLD = 8,
    parameter int STABLE   = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready_in,
    output logic       rst_out,
    output logic       released,
    output logic       rel_pulse,
    output logic       timeout_err,
    output logic [1:0] state_o
);

    localparam int CNT_W = rst_seq_cnt_w(MIN_HOLD, TIMEOUT);

    rst_seq_state_t state_q, state_d;
    logic rst_out_q, rst_out_d;
    logic released_q, released_d;
    logic rel_pulse_q, rel_pulse_d;
    logic timeout_err_q, timeout_err_d;

    logic hold_tc, stab_tc, to_tc;
    logic hold_en, hold_clr, stab_en, stab_clr, to_en, to_clr;

    // Counters run only in their own state and are zeroed whenever that state is left.
    always_comb begin
        hold_en  = (state_q == HOLD);
        hold_clr = (state_d != HOLD);
        stab_en  = (state_q == WAIT) && ready_in;
        stab_clr = ((state_q == WAIT) && !ready_in) || (state_d != WAIT);
        to_en    = (state_q == WAIT);
        to_clr   = (state_d != WAIT);
    end

    rst_seq_cnt #(.W(CNT_W), .TC(MIN_HOLD - 1)) u_hold_cnt (
        .clk(clk), .rst(rst), .clr(hold_clr), .en(hold_en), .at_tc(hold_tc)
    );

    rst_seq_cnt #(.W(CNT_W), .TC(STABLE - 1)) u_stab_cnt (
        .clk(clk), .rst(rst), .clr(stab_clr), .en(stab_en), .at_tc(stab_tc)
    );

    rst_seq_cnt #(.W(CNT_W), .TC(TIMEOUT - 1)) u_to_cnt (
        .clk(clk), .rst(rst), .clr(to_clr), .en(to_en), .at_tc(to_tc)
    );

    // Next-state and registered-output decisions; release beats timeout on a tie.
    always_comb begin
        state_d       = state_q;
        rst_out_d     = rst_out_q;
        released_d    = released_q;
        rel_pulse_d   = 1'b0;
        timeout_err_d = timeout_err_q;
        case (state_q)
            HOLD: begin
                if (hold_tc)
                    state_d = WAIT;
            end
            WAIT: begin
                if (ready_in && stab_tc) begin
                    state_d     = RUN;
                    rst_out_d   = 1'b0;
                    released_d  = 1'b1;
                    rel_pulse_d = 1'b1;
                end else if (to_tc) begin
                    state_d       = ERR;
                    timeout_err_d = 1'b1;
                end
            end
            RUN: begin
                if (!ready_in) begin
                    state_d    = HOLD;
                    rst_out_d  = 1'b1;
                    released_d = 1'b0;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HOLD;
            rst_out_q     <= 1'b1;
            released_q    <= 1'b0;
            rel_pulse_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_out_q     <= rst_out_d;
            released_q    <= released_d;
            rel_pulse_q   <= rel_pulse_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign rst_out     = rst_out_q;
    assign released    = released_q;
    assign rel_pulse   = rel_pulse_q;
    assign timeout_err = timeout_err_q;
    assign state_o     = state_q;

`ifdef RST_SEQ_SVA_EN
    a_rose_hold: assert property (@(posedge clk) disable iff (rst)
        $rose(rst_out) |-> (rst_out until released))
        $info("a_rose_hold pass"); else $error("a_rose_hold violated");

    a_fell_strong: assert property (@(posedge clk) disable iff (rst)
        $fell(rst) |-> (rst_out s_until (released || timeout_err)))
        $info("a_fell_strong pass"); else $error("a_fell_strong violated");

    a_pulse_ready: assert property (@(posedge clk) disable iff (rst)
        rel_pulse |-> $past(ready_in))
        $info("a_pulse_ready pass"); else $error("a_pulse_ready violated");

    a_err_sticky: assert property (@(posedge clk) disable iff (rst)
        timeout_err |=> timeout_err)
        $info("a_err_sticky pass"); else $error("a_err_sticky violated");
`endif

endmodule

// File: tb/tb_rst_release_seq.sv
// Self-checking bench for rst_release_seq: directed scenarios plus a randomized run,
// every cycle compared against a sequence-age reference model.
module tb_rst_release_seq;

    localparam int MIN_HOLD = 8;
    localparam int STABLE   = 2;
    localparam int TIMEOUT  = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready_in = 1'b0;
    logic       rst_out, released, rel_pulse, timeout_err;
    logic [1:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    rst_release_seq #(.MIN_HOLD(MIN_HOLD), .STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ready_in(ready_in), .rst_out(rst_out),
        .released(released), .rel_pulse(rel_pulse), .timeout_err(timeout_err),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: a sequence starts at some edge; rst_out is released once
    // the ready samples taken after MIN_HOLD edges end in STABLE ones, and errors
    // if the WAIT window reaches TIMEOUT samples without that.
    int  t = 0;
    int  seq_start = 0;
    bit  m_rel = 0, m_err = 0, m_pulse = 0;
    bit  win[$];

    task automatic model_edge(input bit r, input bit rdy);
        int age, run, i;
        m_pulse = 0;
        if (r) begin
            m_rel = 0; m_err = 0; seq_start = t + 1; win.delete();
        end else if (m_err) begin
            m_err = 1;
        end else if (m_rel) begin
            if (!rdy) begin
                m_rel = 0; seq_start = t + 1; win.delete();
            end
        end else begin
            age = t - seq_start;
            if (age >= MIN_HOLD) begin
                win.push_back(rdy);
                run = 0;
                i = win.size() - 1;
                while (i >= 0) begin
                    if (!win[i]) break;
                    run++; i--;
                end
                if (run >= STABLE) begin
                    m_rel = 1; m_pulse = 1;
                end else if (win.size() == TIMEOUT) begin
                    m_err = 1;
                end
            end
        end
        t++;
    endtask

    function automatic int exp_state();
        if (m_err) return 3;
        if (m_rel) return 2;
        return (t - seq_start >= MIN_HOLD) ? 1 : 0;
    endfunction

    task automatic step(input bit r, input bit rdy);
        @(negedge clk);
        rst = r; ready_in = rdy;
        @(posedge clk);
        model_edge(r, rdy);
        #1;
        chk("m_rst_out",   rst_out,     !m_rel);
        chk("m_released",  released,    m_rel);
        chk("m_rel_pulse", rel_pulse,   m_pulse);
        chk("m_timeout",   timeout_err, m_err);
        chk("m_state",     state_o,     exp_state());
    endtask

    initial begin
        int n, cyc;
        bit found, stayed, mode_hi, mode_rand;

        // Reset state
        repeat (3) step(1, 1);
        chk("reset_state",   state_o,     0);
        chk("reset_rst_out", rst_out,     1);
        chk("reset_rel",     released,    0);
        chk("reset_pulse",   rel_pulse,   0);
        chk("reset_err",     timeout_err, 0);

        // Release with ready high from the start
        n = 0; found = 0;
        while (n < 200 && !found) begin
            step(0, 1); n++;
            if (rst_out === 1'b0) found = 1;
        end
        chk("rel_found", found, 1);
        chk("rel_cycle", n + 1, MIN_HOLD + STABLE + 1);
        chk("rel_pulse_hi", rel_pulse, 1);
        step(0, 1);
        chk("rel_pulse_lo", rel_pulse, 0);
        chk("rel_level", released, 1);

        // Glitch during WAIT: 1,0,1,1
        step(1, 0);
        repeat (MIN_HOLD) step(0, 1);
        chk("glitch_in_wait", state_o, 1);
        step(0, 1); chk("glitch_a", rst_out, 1);
        step(0, 0); chk("glitch_b", rst_out, 1);
        step(0, 1); chk("glitch_c", rst_out, 1);
        step(0, 1); chk("glitch_rel", rst_out, 0);

        // Timeout with ready low
        step(1, 0);
        n = 0; found = 0; stayed = 1; cyc = 0;
        while (n < 200) begin
            step(0, 0); n++;
            if (!found && timeout_err === 1'b1) begin
                found = 1; cyc = n + 1;
            end
            if (rst_out !== 1'b1) stayed = 0;
        end
        chk("to_found", found, 1);
        chk("to_cycle", cyc, MIN_HOLD + TIMEOUT + 1);
        chk("to_rst_held", stayed, 1);

        // Same-cycle tie: release must win
        step(1, 0);
        repeat (MIN_HOLD + TIMEOUT - STABLE) step(0, 0);
        step(0, 1);
        step(0, 1);
        chk("tie_rst_out", rst_out, 0);
        chk("tie_no_err", timeout_err, 0);

        // RUN drop: full re-sequence
        step(0, 1); step(0, 1);
        step(0, 0);
        chk("drop_rst_out", rst_out, 1);
        chk("drop_rel", released, 0);
        n = 0; found = 0;
        while (n < 200 && !found) begin
            step(0, 1); n++;
            if (rst_out === 1'b0) found = 1;
        end
        chk("drop_rerel", n, MIN_HOLD + STABLE);

        // Mid-reset during WAIT at to_cnt==20
        step(1, 0);
        repeat (MIN_HOLD + 20) step(0, 0);
        step(1, 0);
        chk("mid_state", state_o, 0);
        chk("mid_rst_out", rst_out, 1);
        chk("mid_rel", released, 0);
        chk("mid_err", timeout_err, 0);
        n = 0; found = 0;
        while (n < 200 && !found) begin
            step(0, 1); n++;
            if (rst_out === 1'b0) found = 1;
        end
        chk("mid_restart", n, MIN_HOLD + STABLE);

        // Randomized run
        mode_hi = 1; mode_rand = 0;
        for (int k = 0; k < 4000; k++) begin
            bit r, d;
            if ($urandom_range(0, 39) == 0) begin
                mode_hi = $urandom_range(0, 1);
                mode_rand = $urandom_range(0, 1);
            end
            r = ($urandom_range(0, 299) == 0);
            if (mode_rand) d = $urandom_range(0, 1);
            else if (mode_hi) d = ($urandom_range(0, 9) != 0);
            else d = ($urandom_range(0, 9) == 0);
            step(r, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
